// File: rtl/pll_region_reconfig.sv
// Purpose: reprogram the PLL M/K counters (optionally C counters) through the reconfig management port to switch the NES clocks between NTSC and PAL.
// Latency: 1 cycle IDLE->WR_MODE, then 2 cycles per write with no stall, then LOCK_STABLE locked cycles (or LOCK_TIMEOUT) before returning to IDLE.
// Backpressure: mgmt_waitrequest stalls the current write with address/data held; one write in flight. Optional macro: PLLRC_CWRITE_EN adds C0..C2 writes.
module pll_region_reconfig #(
    parameter logic [31:0] NTSC_M       = 32'h0000_0404,
    parameter logic [31:0] NTSC_K       = 32'd2537933971,
    parameter logic [31:0] PAL_M        = 32'h0000_0505,
    parameter logic [31:0] PAL_K        = 32'd2751720263,
    parameter int          LOCK_STABLE  = 1024,
    parameter int          LOCK_TIMEOUT = 2_000_000
) (
    input  logic        refclk,
    input  logic        rst,
    input  logic        pal_req,
    input  logic        locked,
    input  logic        mgmt_waitrequest,
    output logic [5:0]  mgmt_address,
    output logic        mgmt_write,
    output logic [31:0] mgmt_writedata,
    output logic        busy,
    output logic        pal_active,
    output logic        core_reset,
    output logic        timeout_err
);

    localparam int SW = $clog2(LOCK_STABLE + 1);
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);

    // C counter words: index in [22:18], odd in [17], hi in [15:8], lo in [7:0]
    localparam logic [31:0] C0_WORD = 32'h0002_0302;
    localparam logic [31:0] C1_WORD = 32'h0004_0505;
    localparam logic [31:0] C2_WORD = 32'h0008_0A0A;

    typedef enum logic [3:0] {
        S_INIT,
        S_IDLE,
        S_WR_MODE,
        S_WR_M,
        S_WR_K,
`ifdef PLLRC_CWRITE_EN
        S_WR_C0,
        S_WR_C1,
        S_WR_C2,
`endif
        S_START,
        S_WAIT_LOCK
    } state_t;

    state_t         state;
    state_t         next_state;
    logic           locked_s1;
    logic           locked_sync;
    logic           locked_prev;
    logic           target;
    logic           wr_done;
    logic [SW-1:0]  stable_cnt;
    logic [TW-1:0]  timeout_cnt;
    logic           is_wr_state;
    logic           counting;
    logic           stable_hit;
    logic           timeout_hit;

    // Flags shared by the next-state logic and the datapath
    always_comb begin
        is_wr_state = 1'b0;
        case (state)
            S_WR_MODE, S_WR_M, S_WR_K, S_START: is_wr_state = 1'b1;
`ifdef PLLRC_CWRITE_EN
            S_WR_C0, S_WR_C1, S_WR_C2:          is_wr_state = 1'b1;
`endif
            default:                            is_wr_state = 1'b0;
        endcase
        counting    = (state == S_INIT) || (state == S_WAIT_LOCK);
        stable_hit  = counting && locked_sync && (stable_cnt == SW'(LOCK_STABLE - 1));
        timeout_hit = counting && (timeout_cnt == TW'(LOCK_TIMEOUT - 1));
    end

    // State register
    always_ff @(posedge refclk) begin
        if (rst) state <= S_INIT;
        else     state <= next_state;
    end

    // Next-state logic; write states advance on the drop cycle after acceptance
    always_comb begin
        next_state = state;
        case (state)
            S_INIT:      if (stable_hit) next_state = S_IDLE;
            S_IDLE: begin
                if (!locked_sync && !locked_prev) next_state = S_INIT;
                else if (pal_req != pal_active)   next_state = S_WR_MODE;
            end
            S_WR_MODE:   if (wr_done) next_state = S_WR_M;
            S_WR_M:      if (wr_done) next_state = S_WR_K;
`ifdef PLLRC_CWRITE_EN
            S_WR_K:      if (wr_done) next_state = S_WR_C0;
            S_WR_C0:     if (wr_done) next_state = S_WR_C1;
            S_WR_C1:     if (wr_done) next_state = S_WR_C2;
            S_WR_C2:     if (wr_done) next_state = S_START;
`else
            S_WR_K:      if (wr_done) next_state = S_START;
`endif
            S_START:     if (wr_done) next_state = S_WAIT_LOCK;
            S_WAIT_LOCK: if (stable_hit || timeout_hit) next_state = S_IDLE;
            default:     next_state = S_INIT;
        endcase
    end

    // Lock synchronizer, write handshake, lock/timeout counters and region status
    always_ff @(posedge refclk) begin
        if (rst) begin
            locked_s1   <= 1'b0;
            locked_sync <= 1'b0;
            locked_prev <= 1'b0;
            target      <= 1'b0;
            wr_done     <= 1'b0;
            stable_cnt  <= '0;
            timeout_cnt <= '0;
            pal_active  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            locked_s1   <= locked;
            locked_sync <= locked_s1;
            locked_prev <= locked_sync;
            wr_done     <= mgmt_write && !mgmt_waitrequest;
            if (state == S_IDLE && next_state == S_WR_MODE) target <= pal_req;
            if (counting) begin
                if (!locked_sync)                        stable_cnt <= '0;
                else if (stable_cnt < SW'(LOCK_STABLE))  stable_cnt <= stable_cnt + SW'(1);
                if (timeout_cnt < TW'(LOCK_TIMEOUT))     timeout_cnt <= timeout_cnt + TW'(1);
            end else begin
                stable_cnt  <= '0;
                timeout_cnt <= '0;
            end
            if (stable_hit)       timeout_err <= 1'b0;
            else if (timeout_hit) timeout_err <= 1'b1;
            if (state == S_WAIT_LOCK && (stable_hit || timeout_hit)) pal_active <= target;
        end
    end

    // Management bus and status outputs decoded from state
    always_comb begin
        mgmt_write     = is_wr_state && !wr_done;
        mgmt_address   = 6'h00;
        mgmt_writedata = 32'h0;
        busy           = (state != S_IDLE);
        core_reset     = (state != S_IDLE);
        case (state)
            S_WR_M: begin
                mgmt_address   = 6'h04;
                mgmt_writedata = target ? PAL_M : NTSC_M;
            end
            S_WR_K: begin
                mgmt_address   = 6'h07;
                mgmt_writedata = target ? PAL_K : NTSC_K;
            end
`ifdef PLLRC_CWRITE_EN
            S_WR_C0: begin
                mgmt_address   = 6'h05;
                mgmt_writedata = C0_WORD;
            end
            S_WR_C1: begin
                mgmt_address   = 6'h05;
                mgmt_writedata = C1_WORD;
            end
            S_WR_C2: begin
                mgmt_address   = 6'h05;
                mgmt_writedata = C2_WORD;
            end
`endif
            S_START: begin
                mgmt_address   = 6'h02;
                mgmt_writedata = 32'h1;
            end
            default: begin
                mgmt_address   = 6'h00;
                mgmt_writedata = 32'h0;
            end
        endcase
    end

endmodule

// File: tb/tb_pll_region_reconfig.sv
// Directed bench for pll_region_reconfig: reset table, region switches, stalled write, mid-switch request change, lock timeout, reset mid-write.
// Inputs driven 1 time unit after the rising edge; accepted writes captured on the falling edge.
// Timeout shortened through the LOCK_TIMEOUT parameter to keep run time small.
module tb_pll_region_reconfig;

    localparam int          TB_TIMEOUT = 5000;
    localparam logic [31:0] NTSC_M = 32'h0000_0404;
    localparam logic [31:0] NTSC_K = 32'd2537933971;
    localparam logic [31:0] PAL_M  = 32'h0000_0505;
    localparam logic [31:0] PAL_K  = 32'd2751720263;
`ifdef PLLRC_CWRITE_EN
    localparam int SEQ_LEN = 7;
`else
    localparam int SEQ_LEN = 4;
`endif

    logic        refclk = 1'b0;
    logic        rst;
    logic        pal_req;
    logic        locked;
    logic        mgmt_waitrequest;
    logic [5:0]  mgmt_address;
    logic        mgmt_write;
    logic [31:0] mgmt_writedata;
    logic        busy;
    logic        pal_active;
    logic        core_reset;
    logic        timeout_err;

    pll_region_reconfig #(.LOCK_TIMEOUT(TB_TIMEOUT)) dut (
        .refclk           (refclk),
        .rst              (rst),
        .pal_req          (pal_req),
        .locked           (locked),
        .mgmt_waitrequest (mgmt_waitrequest),
        .mgmt_address     (mgmt_address),
        .mgmt_write       (mgmt_write),
        .mgmt_writedata   (mgmt_writedata),
        .busy             (busy),
        .pal_active       (pal_active),
        .core_reset       (core_reset),
        .timeout_err      (timeout_err)
    );

    always #10 refclk = ~refclk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [5:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t wq[$];
    wr_t exp_q[$];

    // Record every write the reconfig IP would accept on the coming edge
    always @(negedge refclk) begin
        if (rst === 1'b0 && mgmt_write === 1'b1 && mgmt_waitrequest === 1'b0)
            wq.push_back({mgmt_address, mgmt_writedata});
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge refclk);
            #1;
        end
    endtask

    task automatic add_seq(input bit pal);
        exp_q.push_back({6'h00, 32'h0});
        exp_q.push_back({6'h04, pal ? PAL_M : NTSC_M});
        exp_q.push_back({6'h07, pal ? PAL_K : NTSC_K});
`ifdef PLLRC_CWRITE_EN
        exp_q.push_back({6'h05, 32'h0002_0302});
        exp_q.push_back({6'h05, 32'h0004_0505});
        exp_q.push_back({6'h05, 32'h0008_0A0A});
`endif
        exp_q.push_back({6'h02, 32'h1});
    endtask

    // Compare captured writes against the expected table, then clear both
    task automatic compare_writes(input string name);
        check({name, "_count"}, wq.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < wq.size()) begin
                check($sformatf("%s_addr%0d", name, i), 32'(wq[i].addr), 32'(exp_q[i].addr));
                check($sformatf("%s_data%0d", name, i), wq[i].data, exp_q[i].data);
            end
        end
        wq.delete();
        exp_q.delete();
    endtask

    task automatic wait_idle(input int bound, input string name);
        int k = 0;
        while (busy !== 1'b0 && k < bound) begin
            step(1);
            k++;
        end
        check(name, 32'(busy), 32'h0);
    endtask

    task automatic wait_writes(input int n, input int bound, input string name);
        int k = 0;
        while (wq.size() < n && k < bound) begin
            step(1);
            k++;
        end
        check(name, wq.size(), n);
    endtask

    task automatic wait_wr_addr(input logic [5:0] addr, input int bound, input string name);
        int k = 0;
        while (!(mgmt_write === 1'b1 && mgmt_address === addr) && k < bound) begin
            step(1);
            k++;
        end
        check(name, {25'h0, mgmt_write, mgmt_address}, {25'h0, 1'b1, addr});
    endtask

    function automatic logic [31:0] out_sig(input int i);
        case (i)
            0:       return 32'(busy);
            1:       return 32'(core_reset);
            2:       return 32'(pal_active);
            3:       return 32'(timeout_err);
            4:       return 32'(mgmt_write);
            5:       return 32'(mgmt_address);
            default: return mgmt_writedata;
        endcase
    endfunction

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } out_vec_t;

    out_vec_t rst_tab[7];

    initial begin
        int stall_bad;
        rst_tab[0] = '{"rst_busy",        0, 32'h1};
        rst_tab[1] = '{"rst_core_reset",  1, 32'h1};
        rst_tab[2] = '{"rst_pal_active",  2, 32'h0};
        rst_tab[3] = '{"rst_timeout_err", 3, 32'h0};
        rst_tab[4] = '{"rst_mgmt_write",  4, 32'h0};
        rst_tab[5] = '{"rst_mgmt_address",5, 32'h0};
        rst_tab[6] = '{"rst_mgmt_wdata",  6, 32'h0};

        rst = 1'b1;
        pal_req = 1'b0;
        locked = 1'b1;
        mgmt_waitrequest = 1'b0;
        step(3);
        for (int i = 0; i < 7; i++) check(rst_tab[i].name, out_sig(rst_tab[i].sel), rst_tab[i].exp);

        // Power-on lock qualification
        rst = 1'b0;
        step(1000);
        check("init_hold_busy", 32'(busy), 32'h1);
        step(40);
        check("init_busy", 32'(busy), 32'h0);
        check("init_core_reset", 32'(core_reset), 32'h0);
        check("init_pal_active", 32'(pal_active), 32'h0);
        check("init_no_writes", wq.size(), 0);

        // Switch to PAL with no stalls
        pal_req = 1'b1;
        step(1);
        check("pal_core_reset_1cyc", 32'(core_reset), 32'h1);
        check("pal_wr_mode", {25'h0, mgmt_write, mgmt_address}, {25'h0, 1'b1, 6'h00});
        step(2 * SEQ_LEN - 2);
        check("pal_latency_pre", wq.size(), SEQ_LEN - 1);
        step(1);
        check("pal_latency", wq.size(), SEQ_LEN);
        step(1);
        check("pal_wait_lock_busy", 32'(busy), 32'h1);
        locked = 1'b0;
        step(200);
        locked = 1'b1;
        step(1000);
        check("pal_not_early", 32'(busy), 32'h1);
        wait_idle(200, "pal_idle");
        check("pal_active_set", 32'(pal_active), 32'h1);
        check("pal_core_released", 32'(core_reset), 32'h0);
        check("pal_no_timeout", 32'(timeout_err), 32'h0);
        add_seq(1'b1);
        compare_writes("pal_seq");

        // Switch to NTSC with a 50-cycle stall on the K write
        pal_req = 1'b0;
        wait_wr_addr(6'h07, 40, "stall_reach_k");
        mgmt_waitrequest = 1'b1;
        stall_bad = 0;
        for (int i = 0; i < 50; i++) begin
            step(1);
            if (mgmt_write !== 1'b1 || mgmt_address !== 6'h07 || mgmt_writedata !== NTSC_K) stall_bad++;
        end
        check("stall_hold_stable", stall_bad, 0);
        check("stall_no_accept", wq.size(), 2);
        mgmt_waitrequest = 1'b0;
        wait_idle(1300, "ntsc_idle");
        check("ntsc_active", 32'(pal_active), 32'h0);
        add_seq(1'b0);
        compare_writes("ntsc_seq");

        // Request flips back during the M write: PAL completes, then NTSC follows
        pal_req = 1'b1;
        wait_wr_addr(6'h04, 40, "toggle_reach_m");
        pal_req = 1'b0;
        wait_idle(1300, "toggle_first_idle");
        check("toggle_pal_done", 32'(pal_active), 32'h1);
        step(1);
        check("toggle_restart", 32'(busy), 32'h1);
        wait_idle(1300, "toggle_second_idle");
        check("toggle_ntsc_done", 32'(pal_active), 32'h0);
        add_seq(1'b1);
        add_seq(1'b0);
        compare_writes("toggle_seq");

        // Lock never returns: timeout, then lock loss sends it to INIT
        pal_req = 1'b1;
        wait_writes(SEQ_LEN, 40, "to_writes");
        locked = 1'b0;
        step(TB_TIMEOUT - 20);
        check("to_not_early", 32'(busy), 32'h1);
        wait_idle(100, "to_idle");
        check("to_err_set", 32'(timeout_err), 32'h1);
        check("to_pal_active", 32'(pal_active), 32'h1);
        step(3);
        check("to_lockloss_busy", 32'(busy), 32'h1);
        check("to_lockloss_core_rst", 32'(core_reset), 32'h1);
        add_seq(1'b1);
        compare_writes("to_seq");
        locked = 1'b1;
        wait_idle(1300, "relock_idle");
        check("relock_err_cleared", 32'(timeout_err), 32'h0);
        check("relock_pal_kept", 32'(pal_active), 32'h1);
        check("relock_no_writes", wq.size(), 0);

        // Reset in the middle of a write
        pal_req = 1'b0;
        wait_wr_addr(6'h04, 40, "rst_reach_m");
        rst = 1'b1;
        step(1);
        check("midrst_write", 32'(mgmt_write), 32'h0);
        check("midrst_pal_active", 32'(pal_active), 32'h0);
        check("midrst_core_reset", 32'(core_reset), 32'h1);
        rst = 1'b0;
        step(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
